// File: rtl/hex_display_scanner_pkg.sv
// Shared types and defaults for the hex display scan controller.
// No logic: scan FSM state encoding, nibble type, default digit count.
package hex_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } scan_state_t;

  typedef logic [3:0] nibble_t;

  localparam int DEFAULT_NUM_DIGITS = 4;

endpackage

// File: rtl/hex_display_scanner_scan_timer.sv
// Loadable down-counter with terminal-count flag, shared by the SHOW and GAP phases.
// Latency: count updates one cycle after ld/clr; tc is decoded from the count register; no backpressure.
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex scan controller with dead-time gaps and frame-boundary value updates.
// Latency: registered outputs, no input-to-output path; no backpressure. Option: HEX_SCAN_LEADING_ZERO_BLANK_EN.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output nibble_t                 nibble,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank,
  output logic                    frame_done
);

  localparam int MAXC = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [CW-1:0] SHOW_LD = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_t             state;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_nx;
  logic [IW-1:0]           show_idx;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] active_nx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pending_valid;
  logic                    tc;
  logic                    show_end;
  logic                    advance;
  logic                    wrap;
  logic                    frame_start;
  logic                    show_lit;
  logic                    tmr_ld;
  logic [CW-1:0]           tmr_val;
  nibble_t                 show_nib;

  always_comb begin
    show_end    = (state == SHOW) && tc;
    advance     = enable && ((show_end && !HAS_GAP) || ((state == GAP) && tc));
    wrap        = advance && (idx == LAST_IDX);
    frame_start = enable && ((state == IDLE) || wrap);
    idx_nx      = wrap ? '0 : idx + IW'(1);
    show_idx    = (state == IDLE) ? '0 : idx_nx;
    // The displayed value only ever changes here, at a frame start.
    active_nx   = active;
    if (frame_start) begin
      if (load) begin
        active_nx = value;
      end else if (pending_valid) begin
        active_nx = pending;
      end
    end
    show_nib = active_nx[{show_idx, 2'b00} +: 4];
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    show_lit = (show_idx == '0) || (|(active_nx >> {show_idx, 2'b00}));
`else
    show_lit = 1'b1;
`endif
    tmr_ld  = enable && ((state == IDLE) || advance || show_end);
    tmr_val = (show_end && HAS_GAP) ? GAP_LD : SHOW_LD;
  end

  scan_timer #(
    .W(CW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!enable),
    .ld    (tmr_ld),
    .ld_val(tmr_val),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      nibble        <= '0;
      digit_sel     <= '0;
      blank         <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      active     <= active_nx;
      if (load && !frame_start) begin
        pending       <= value;
        pending_valid <= 1'b1;
      end else if (frame_start && !load) begin
        pending_valid <= 1'b0;
      end

      if (!enable) begin
        state     <= IDLE;
        idx       <= '0;
        nibble    <= '0;
        digit_sel <= '0;
        blank     <= 1'b1;
      end else if ((state == IDLE) || advance) begin
        state      <= SHOW;
        idx        <= show_idx;
        nibble     <= show_nib;
        digit_sel  <= show_lit ? (NUM_DIGITS'(1) << show_idx) : '0;
        blank      <= !show_lit;
        frame_done <= wrap;
      end else if (show_end) begin
        // nibble is left alone so the decoder input stays stable through the gap.
        state     <= GAP;
        digit_sel <= '0;
        blank     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: two instances (gap 1 and gap 0) checked every cycle
// against a frame-position reference model; directed scenarios followed by random stimulus.
module tb_hex_display_scanner;

  localparam int N = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;

  logic [3:0] nib [2];
  logic [3:0] sel [2];
  logic       blank [2];
  logic       fd [2];

  int n_chk = 0;
  int n_err = 0;

  bit          m_run [2];
  int          m_pos [2];
  logic [15:0] m_act [2];
  logic [15:0] m_pend [2];
  bit          m_pv [2];
  bit          m_fd [2];

  always #5 clk = ~clk;

  hex_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(1)) u_gap1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .nibble(nib[0]), .digit_sel(sel[0]), .blank(blank[0]), .frame_done(fd[0])
  );

  hex_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .nibble(nib[1]), .digit_sel(sel[1]), .blank(blank[1]), .frame_done(fd[1])
  );

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k]  = 1'b0;
      m_pos[k]  = 0;
      m_act[k]  = '0;
      m_pend[k] = '0;
      m_pv[k]   = 1'b0;
      m_fd[k]   = 1'b0;
    end
  endtask

  // Position within the frame advances one per cycle; a frame is N slots of R lit + gap dark cycles.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit fs;
      int flen;
      fs = 1'b0;
      m_fd[k] = 1'b0;
      flen = N * (R + gap_of(k));
      if (!enable) begin
        m_run[k] = 1'b0;
      end else if (!m_run[k]) begin
        m_run[k] = 1'b1;
        m_pos[k] = 0;
        fs = 1'b1;
      end else begin
        m_pos[k]++;
        if (m_pos[k] == flen) begin
          m_pos[k] = 0;
          fs = 1'b1;
          m_fd[k] = 1'b1;
        end
      end
      if (fs) begin
        if (load) begin
          m_act[k] = value;
        end else if (m_pv[k]) begin
          m_act[k] = m_pend[k];
          m_pv[k] = 1'b0;
        end
      end else if (load) begin
        m_pend[k] = value;
        m_pv[k] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      int slot;
      int d;
      int w;
      bit lit;
      logic [3:0] e_nib;
      logic [3:0] e_sel;
      bit e_blank;
      slot = R + gap_of(k);
      e_nib = 4'h0;
      e_sel = 4'h0;
      e_blank = 1'b1;
      if (m_run[k]) begin
        d = m_pos[k] / slot;
        w = m_pos[k] % slot;
        lit = (w < R);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        if (d > 0 && (m_act[k] >> (4 * d)) == 16'h0) lit = 1'b0;
`endif
        e_nib = 4'((m_act[k] >> (4 * d)) & 16'hF);
        e_sel = lit ? 4'(1 << d) : 4'h0;
        e_blank = !lit;
      end
      chk($sformatf("digit_sel[gap%0d]", gap_of(k)), 32'(sel[k]), 32'(e_sel));
      chk($sformatf("blank[gap%0d]", gap_of(k)), 32'(blank[k]), 32'(e_blank));
      chk($sformatf("nibble[gap%0d]", gap_of(k)), 32'(nib[k]), 32'(e_nib));
      chk($sformatf("frame_done[gap%0d]", gap_of(k)), 32'(fd[k]), 32'(m_fd[k]));
    end
  endtask

  // Called at a falling edge; inputs are held across the following rising edge.
  task automatic cycle(input logic en, input logic ld, input logic [15:0] v);
    enable = en;
    load = ld;
    value = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    cycle(1'b1, 1'b1, 16'h1A2F);
    repeat (45) cycle(1'b1, 1'b0, 16'h0);

    // Load zeros while digit 1 is on screen.
    for (int i = 0; i < 40 && (m_pos[0] / 5) != 1; i++) cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h0000);
    repeat (45) cycle(1'b1, 1'b0, 16'h0);

    // Load exactly on a frame start of the gapped instance.
    for (int i = 0; i < 40 && m_pos[0] != N * 5 - 1; i++) cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'hBEEF);
    repeat (22) cycle(1'b1, 1'b0, 16'h0);

    // Two loads in one frame: the later one wins.
    for (int i = 0; i < 40 && m_pos[0] != 2; i++) cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h1111);
    repeat (3) cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h2222);
    repeat (45) cycle(1'b1, 1'b0, 16'h0);

    // Drop enable while digit 2 is lit, then restart.
    for (int i = 0; i < 40 && !(m_pos[0] >= 10 && m_pos[0] <= 13); i++) cycle(1'b1, 1'b0, 16'h0);
    repeat (3) cycle(1'b0, 1'b0, 16'h0);
    repeat (30) cycle(1'b1, 1'b0, 16'h0);

    // Asynchronous reset in the middle of a lit slot.
    for (int i = 0; i < 40 && !(m_run[0] && (m_pos[0] % 5) == 1); i++) cycle(1'b1, 1'b0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_digit_sel[gap%0d]", gap_of(k)), 32'(sel[k]), 32'h0);
      chk($sformatf("arst_blank[gap%0d]", gap_of(k)), 32'(blank[k]), 32'h1);
      chk($sformatf("arst_nibble[gap%0d]", gap_of(k)), 32'(nib[k]), 32'h0);
      chk($sformatf("arst_frame_done[gap%0d]", gap_of(k)), 32'(fd[k]), 32'h0);
    end
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Leading-zero cases (only blank when the option is compiled in).
    cycle(1'b1, 1'b1, 16'h0030);
    repeat (22) cycle(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 40 && m_pos[0] != N * 5 - 1; i++) cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h0000);
    repeat (22) cycle(1'b1, 1'b0, 16'h0);

    for (int i = 0; i < 800; i++) begin
      logic [15:0] mask;
      logic [15:0] v;
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      v = 16'($urandom) & mask;
      cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
